// File: rtl/dlf_gain_sched.sv
// Digital loop filter gain scheduler: watches PFD balance per window and steps Kp from acquisition to tracking gain.
// Optional linear Kp ramp through a SETTLE state is enabled with macro DLF_GAIN_RAMP_EN.
module dlf_gain_sched #(
  parameter int WIN_LOG2  = 5,
  parameter int TOL       = 4,
  parameter int LOCK_WINS = 4,
  parameter int KP_STEP   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  input  logic       enable,
  input  logic [7:0] kp_acq,
  input  logic [7:0] kp_trk,
  output logic [7:0] kp,
  output logic       locked,
  output logic [1:0] state,
  output logic       win_end
);

  localparam int WIN_LEN = 1 << WIN_LOG2;
  localparam int HALF    = WIN_LEN / 2;
  localparam int GW      = $clog2(LOCK_WINS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    SETTLE = 2'd2,
    TRACK  = 2'd3
  } st_t;

  st_t                 st_q, st_d;
  logic [WIN_LOG2-1:0] wcnt_q, wcnt_d;
  logic [WIN_LOG2:0]   ones_q, ones_d, ones_tot;
  logic [GW-1:0]       good_q, good_d, good_inc;
  logic                miss_q, miss_d;
  logic [7:0]          kp_q, kp_d;
  logic                locked_q, locked_d;
  logic [7:0]          kpa_q, kpa_d;
  logic [7:0]          kpt_q, kpt_d;
  logic                bal;

  // Window is balanced when the ones count sits within TOL of half the window length.
  function automatic logic is_balanced(input logic [WIN_LOG2:0] n);
    logic signed [WIN_LOG2+1:0] d;
    d = $signed({1'b0, n}) - $signed((WIN_LOG2+2)'(HALF));
    if (d < 0) d = -d;
    return d <= $signed((WIN_LOG2+2)'(TOL));
  endfunction

`ifdef DLF_GAIN_RAMP_EN
  // Step Kp down by KP_STEP, saturating at the tracking gain (never underflows).
  function automatic logic [7:0] kp_ramp(input logic [7:0] cur, input logic [7:0] trk);
    if (cur > trk && (cur - trk) > 8'(KP_STEP)) return cur - 8'(KP_STEP);
    return trk;
  endfunction
`endif

  assign win_end  = (st_q != IDLE) && (&wcnt_q);
  assign ones_tot = ones_q + (WIN_LOG2+1)'(in);
  assign good_inc = good_q + 1'b1;
  assign bal      = is_balanced(ones_tot);

  always_comb begin
    st_d     = st_q;
    wcnt_d   = wcnt_q + 1'b1;
    ones_d   = win_end ? '0 : ones_tot;
    good_d   = good_q;
    miss_d   = miss_q;
    kp_d     = kp_q;
    locked_d = locked_q;
    kpa_d    = kpa_q;
    kpt_d    = kpt_q;

    if (!enable || st_q == IDLE) begin
      wcnt_d   = '0;
      ones_d   = '0;
      good_d   = '0;
      miss_d   = 1'b0;
      locked_d = 1'b0;
      if (st_q == IDLE) kp_d = kp_acq;
      if (!enable) begin
        st_d = IDLE;
      end else begin
        st_d  = ACQ;
        kpa_d = kp_acq;
        kpt_d = kp_trk;
      end
    end else if (win_end) begin
      case (st_q)
        ACQ: begin
          if (!bal) begin
            good_d = '0;
          end else if (good_inc == GW'(LOCK_WINS)) begin
            good_d = '0;
`ifdef DLF_GAIN_RAMP_EN
            st_d = SETTLE;
`else
            st_d     = TRACK;
            kp_d     = kpt_q;
            locked_d = 1'b1;
`endif
          end else begin
            good_d = good_inc;
          end
        end
        SETTLE: begin
`ifdef DLF_GAIN_RAMP_EN
          if (bal) begin
            kp_d = kp_ramp(kp_q, kpt_q);
            if (kp_d == kpt_q) begin
              st_d     = TRACK;
              locked_d = 1'b1;
            end
          end else begin
            st_d   = ACQ;
            kp_d   = kpa_q;
            good_d = '0;
          end
`else
          st_d = ACQ;
`endif
        end
        TRACK: begin
          if (bal) begin
            miss_d = 1'b0;
          end else if (miss_q) begin
            st_d     = ACQ;
            kp_d     = kpa_q;
            locked_d = 1'b0;
            miss_d   = 1'b0;
            good_d   = '0;
          end else begin
            miss_d = 1'b1;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      wcnt_q   <= '0;
      ones_q   <= '0;
      good_q   <= '0;
      miss_q   <= 1'b0;
      kp_q     <= 8'h00;
      locked_q <= 1'b0;
      kpa_q    <= 8'h00;
      kpt_q    <= 8'h00;
    end else begin
      st_q     <= st_d;
      wcnt_q   <= wcnt_d;
      ones_q   <= ones_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      kp_q     <= kp_d;
      locked_q <= locked_d;
      kpa_q    <= kpa_d;
      kpt_q    <= kpt_d;
    end
  end

  assign kp     = kp_q;
  assign locked = locked_q;
  assign state  = st_q;

endmodule

// File: tb/tb_dlf_gain_sched.sv
// Bench for dlf_gain_sched: directed scenarios then random traffic, compared every cycle to a window-level model.
module tb_dlf_gain_sched;

  localparam int WIN  = 32;
  localparam int HALF = 16;
  localparam int TOL  = 4;
  localparam int LOCK = 4;
  localparam int STEP = 4;
`ifdef DLF_GAIN_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, in, enable;
  logic [7:0] kp_acq, kp_trk, kp;
  logic       locked, win_end;
  logic [1:0] state;

  dlf_gain_sched #(.WIN_LOG2(5), .TOL(TOL), .LOCK_WINS(LOCK), .KP_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .enable(enable),
    .kp_acq(kp_acq), .kp_trk(kp_trk),
    .kp(kp), .locked(locked), .state(state), .win_end(win_end)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  bit seen_settle = 1'b0;

  // Reference model: state as integers, window samples collected in a queue.
  int m_st, m_kp, m_lk, m_pos, m_good, m_miss, m_kpa, m_kpt;
  int m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_edge(input bit r, input bit e, input bit b, input int ka, input int kt);
    bit we, bal;
    int ones, nk;
    if (!r) begin
      m_st = 0; m_kp = 0; m_lk = 0; m_pos = 0; m_good = 0; m_miss = 0; m_kpa = 0; m_kpt = 0;
      m_q.delete();
      return;
    end
    we = (m_st != 0) && (m_pos == WIN - 1);
    if (m_st != 0) m_q.push_back(int'(b));
    if (!e) begin
      if (m_st == 0) m_kp = ka;
      m_st = 0; m_pos = 0; m_good = 0; m_miss = 0; m_lk = 0;
      m_q.delete();
      return;
    end
    if (m_st == 0) begin
      m_st = 1; m_kp = ka; m_kpa = ka; m_kpt = kt; m_pos = 0; m_good = 0; m_miss = 0; m_lk = 0;
      m_q.delete();
      return;
    end
    if (!we) begin
      m_pos++;
      return;
    end
    ones = 0;
    foreach (m_q[i]) ones += m_q[i];
    m_q.delete();
    m_pos = 0;
    bal = (ones - HALF <= TOL) && (HALF - ones <= TOL);
    case (m_st)
      1: if (bal) begin
           m_good++;
           if (m_good == LOCK) begin
             m_good = 0;
             if (RAMP) m_st = 2;
             else begin m_st = 3; m_kp = m_kpt; m_lk = 1; end
           end
         end else m_good = 0;
      2: if (bal) begin
           nk = m_kp - STEP;
           if (nk < m_kpt) nk = m_kpt;
           m_kp = nk;
           if (m_kp == m_kpt) begin m_st = 3; m_lk = 1; end
         end else begin
           m_st = 1; m_kp = m_kpa; m_good = 0;
         end
      3: if (bal) m_miss = 0;
         else begin
           m_miss++;
           if (m_miss == 2) begin m_st = 1; m_kp = m_kpa; m_lk = 0; m_miss = 0; m_good = 0; end
         end
      default: ;
    endcase
  endtask

  task automatic cyc(input bit r, input bit e, input bit b);
    rst_n = r; enable = e; in = b;
    @(posedge clk);
    model_edge(r, e, b, int'(kp_acq), int'(kp_trk));
    #1;
    check("state", 32'(state), 32'(m_st));
    check("kp", 32'(kp), 32'(m_kp));
    check("locked", 32'(locked), 32'(m_lk));
    check("win_end", 32'(win_end), 32'((m_st != 0) && (m_pos == WIN - 1)));
    if (state == 2'd2) seen_settle = 1'b1;
  endtask

  // One aligned window: alternating bits, or exactly n ones.
  task automatic win(input int n, input bit alt);
    for (int k = 0; k < WIN; k++) cyc(1'b1, 1'b1, alt ? bit'(k % 2 == 0) : bit'(k < n));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; in = 1'b1; kp_acq = 8'd64; kp_trk = 8'd16;

    // Reset held with enable and in high
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    check("rst_kp", 32'(kp), 32'h0);
    check("rst_state", 32'(state), 32'h0);

    // Acquisition with balanced alternating input
    cyc(1'b1, 1'b1, 1'b0);
    check("acq_entry", 32'(state), 32'd1);
    for (int w = 0; w < 16; w++) win(0, 1'b1);
    check("trk_state", 32'(state), 32'd3);
    check("trk_kp", 32'(kp), 32'd16);
    check("trk_locked", 32'(locked), 32'd1);

    // Loss of lock: two fully-ones windows
    win(32, 1'b0);
    win(32, 1'b0);
    check("lol_state", 32'(state), 32'd1);
    check("lol_kp", 32'(kp), 32'd64);
    check("lol_locked", 32'(locked), 32'd0);

    // Balance boundary: 20 ones is balanced
    for (int w = 0; w < 3; w++) win(0, 1'b1);
    win(20, 1'b0);
    check("bnd20_state", 32'(state), RAMP ? 32'd2 : 32'd3);

    // 21 ones clears the good count
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    for (int w = 0; w < 3; w++) win(0, 1'b1);
    win(21, 1'b0);
    for (int w = 0; w < 3; w++) win(0, 1'b1);
    check("bnd21_state", 32'(state), 32'd1);
    win(0, 1'b1);
    check("relock_state", 32'(state), RAMP ? 32'd2 : 32'd3);

    // Enable dropped on a win_end cycle
    win(0, 1'b1);
    for (int k = 0; k < WIN - 1; k++) cyc(1'b1, 1'b1, bit'(k % 2 == 0));
    kp_acq = 8'd100;
    cyc(1'b1, 1'b0, 1'b0);
    check("en_idle", 32'(state), 32'd0);
    check("en_win_end", 32'(win_end), 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    check("en_kp", 32'(kp), 32'd100);
    kp_acq = 8'd64;
    cyc(1'b1, 1'b1, 1'b0);
    for (int w = 0; w < 3; w++) win(0, 1'b1);
    check("en_restart", 32'(state), 32'd1);

    // Random traffic with biased windows, enable drops and resets
    begin
      int bias = 16;
      for (int i = 0; i < 3000; i++) begin
        if (i % WIN == 0) bias = $urandom_range(22, 10);
        if ($urandom_range(299) == 0) begin
          kp_acq = 8'($urandom_range(255));
          kp_trk = 8'($urandom_range(255));
        end
        cyc(bit'($urandom_range(499) != 0), bit'($urandom_range(199) != 0),
            bit'($urandom_range(31) < bias));
      end
    end

    check("settle_seen", 32'(seen_settle), 32'(RAMP));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dlf_gain_sched.md
DLF_GAIN_SCHED -- requirements
Module: dlf_gain_sched

Interface
REQ-001 Parameter WIN_LOG2, default 5, SHALL set the phase-detector observation window to 2^WIN_LOG2 cycles.
REQ-002 Parameter TOL, default 4, SHALL be the maximum |ones - 2^(WIN_LOG2-1)| for a window to count as balanced.
REQ-003 Parameter LOCK_WINS, default 4, SHALL be the number of consecutive balanced windows that declares acquisition complete.
REQ-004 Parameter KP_STEP, default 4, SHALL be the per-window Kp decrement during the SETTLE ramp.
REQ-005 Ports SHALL be as follows; the clock is clk, and reset rst_n is synchronous and active-low:
- clk      in   1  clock
- rst_n    in   1  synchronous active-low reset
- in       in   1  PFD output bit (1 = up, 0 = down)
- enable   in   1  loop-run request
- kp_acq   in   8  acquisition proportional gain
- kp_trk   in   8  tracking proportional gain
- kp       out  8  gain driven to the loop filter Kp input, registered
- locked   out  1  lock indicator, registered
- state    out  2  FSM state: 0 IDLE, 1 ACQ, 2 SETTLE, 3 TRACK
- win_end  out  1  one-cycle pulse on the last cycle of each window

Function
REQ-006 In IDLE, the window counter, ones counter, good-window counter and miss counter SHALL be held at 0, locked=0 and kp=kp_acq (one-cycle registered latency).
REQ-007 In IDLE, if enable=1 the FSM SHALL go to ACQ on the next edge and latch kp_acq and kp_trk into internal registers used until IDLE is re-entered.
REQ-008 Outside IDLE, the window counter SHALL increment every cycle and wrap at 2^WIN_LOG2-1; win_end=1 exactly on the cycle the counter equals 2^WIN_LOG2-1.
REQ-009 The ones count SHALL include every sample in the window, including the win_end cycle, and SHALL restart from 0 (or 1 if in=1) on the cycle after win_end.
REQ-010 Balance SHALL be evaluated only at win_end: |ones - 2^(WIN_LOG2-1)| <= TOL is balanced, with the boundary value equal to TOL counting as balanced.
REQ-011 In ACQ, a balanced window SHALL increment the good count and an unbalanced window SHALL clear it.
REQ-012 In ACQ, when the good count reaches LOCK_WINS at win_end, the FSM SHALL enter SETTLE (or TRACK, see REQ-019) and the good count SHALL clear.
REQ-013 In SETTLE, at each balanced win_end, kp SHALL become max(kp - KP_STEP, latched kp_trk) using unsigned arithmetic with no underflow, and the FSM SHALL enter TRACK when the new kp equals kp_trk.
REQ-014 If latched kp_trk >= kp_acq, SETTLE SHALL set kp=kp_trk and enter TRACK at its first balanced win_end.
REQ-015 In SETTLE, an unbalanced win_end SHALL return the FSM to ACQ with kp=latched kp_acq.
REQ-016 In TRACK, locked SHALL be 1.
REQ-017 In TRACK, an unbalanced win_end SHALL increment the miss count and a balanced win_end SHALL clear it; when the miss count reaches 2, the FSM SHALL go to ACQ with kp=kp_acq, locked=0 and all counters cleared.
REQ-018 enable=0 in any state SHALL force IDLE on the next edge, taking priority over every window-end event in the same cycle.

Configuration
REQ-019 With macro DLF_GAIN_RAMP_EN defined, SETTLE SHALL behave as REQ-013 to REQ-015; without it, SETTLE SHALL be unreachable and ACQ SHALL go directly to TRACK with kp=kp_trk at the completing win_end.

Reset
REQ-020 While rst_n=0 at a clk edge, the block SHALL set state=IDLE, kp=8'h00, locked=0, win_end=0, clear all counters and latched gains, and ignore enable.
REQ-021 Reset asserted mid-operation SHALL abort the current window with no residual count; the first window after release SHALL start on the cycle after IDLE->ACQ.

Verification
REQ-022 The bench SHALL cover reset: rst_n=0 for 3 cycles with enable=1, in=1 -> kp=0x00, locked=0, state=0, win_end=0 throughout.
REQ-023 The bench SHALL cover acquisition with the ramp macro defined: kp_acq=64, kp_trk=16, in alternating 1/0 -> ACQ for 4 windows (128 cycles), SETTLE kp 60,56,...,16 over 12 windows, then TRACK, locked=1.
REQ-024 The bench SHALL cover the balance boundary: an ACQ window with exactly 20 ones -> good count +1; a window with 21 ones -> good count cleared.
REQ-025 The bench SHALL cover loss of lock: in TRACK, in=1 for 64 cycles -> after the 2nd win_end, state=ACQ, kp=64, locked=0.
REQ-026 The bench SHALL cover enable loss: enable=0 mid-SETTLE on a win_end cycle -> state=IDLE on the next edge, counters 0, kp=kp_acq the cycle after.
REQ-027 The bench SHALL cover the no-ramp build: macro undefined, same stimulus as REQ-023 -> kp steps 64 to 16 and locked=1 at the 4th win_end, with state never equal to 2.
